// File: rtl/quad_encoder_emu.sv
// quad_encoder_emu: emulates an incremental quadrature shaft encoder.
//
// A command (step period + direction) is loaded through a pending register and
// becomes active at the next step boundary, or on the following cycle when the
// shaft is halted or disabled. While enabled with a nonzero active period, an
// interval counter fires one A/B transition every P' clocks (P' = max(P, 2)),
// and a signed 32-bit position tracks the net transition count.
//
// Optional feature: define QENC_INDEX_EN to add an edge index (0..EDGES_PER_REV-1)
// and the o_chZ index output, high while the index is 0.
//
// Parameters:
//   EDGES_PER_REV  transitions per revolution (4..65535), used by the index only
//   PERIOD_W       width of the step-period input
// Ports:
//   i_clk          clock, rising edge
//   i_rstn         synchronous active-low reset
//   i_en           step enable; low freezes the shaft
//   i_period       clocks between transitions; 0 halts
//   i_dir          1 forward (A leads B), 0 reverse
//   i_load         one-cycle strobe capturing i_period/i_dir
//   o_pending      a loaded command has not been applied yet
//   o_chA, o_chB   registered quadrature channels
//   o_chZ          registered index channel (QENC_INDEX_EN only)
//   o_step         one-cycle pulse in the cycle A/B changes
//   o_position     signed transition count, wraps modulo 2^32

module quad_encoder_emu #(
  parameter int unsigned EDGES_PER_REV = 48,
  parameter int unsigned PERIOD_W      = 32
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_en,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_dir,
  input  logic                i_load,
  output logic                o_pending,
  output logic                o_chA,
  output logic                o_chB,
`ifdef QENC_INDEX_EN
  output logic                o_chZ,
`endif
  output logic                o_step,
  output logic [31:0]         o_position
);

  // Elaboration-time sanity check on the revolution size.
  if (EDGES_PER_REV < 4 || EDGES_PER_REV > 65535) begin : g_bad_edges
    $error("quad_encoder_emu: EDGES_PER_REV out of range");
  end

  // Quadrature states, numbered in forward order so +1/-1 on the code walks the
  // Gray sequence and a reversal always revisits the previous state.
  localparam logic [1:0] S0 = 2'd0;  // A0 B0
  localparam logic [1:0] S1 = 2'd1;  // A1 B0
  localparam logic [1:0] S2 = 2'd2;  // A1 B1
  localparam logic [1:0] S3 = 2'd3;  // A0 B1

  localparam logic [PERIOD_W-1:0] PeriodOne = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PeriodTwo = PERIOD_W'(2);

  logic [1:0]          state_q, state_d;
  logic                cha_q, cha_d;
  logic                chb_q, chb_d;
  logic                step_q;
  logic [31:0]         pos_q, pos_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] act_period_q, act_period_d;
  logic                act_dir_q, act_dir_d;
  logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
  logic                pend_dir_q, pend_dir_d;
  logic                pending_q, pending_d;

  logic [PERIOD_W-1:0] period_eff;
  logic                running;
  logic                step_now;
  logic                step_dir;

  // Interval timing and step decision.
  always_comb begin
    period_eff = (act_period_q == PeriodOne) ? PeriodTwo : act_period_q;
    running    = i_en && (act_period_q != '0);
    step_now   = running && (cnt_q == (period_eff - PeriodOne));
    // A pending command takes effect at this boundary, so its direction
    // already governs the step that marks the boundary.
    step_dir   = pending_q ? pend_dir_q : act_dir_q;
  end

  // Next-state logic for the shaft, counter and command registers.
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    cnt_d         = cnt_q;
    act_period_d  = act_period_q;
    act_dir_d     = act_dir_q;
    pend_period_d = pend_period_q;
    pend_dir_d    = pend_dir_q;
    pending_d     = pending_q;

    if (step_now) begin
      cnt_d = '0;
      if (step_dir) begin
        state_d = state_q + 2'd1;
        pos_d   = pos_q + 32'd1;
      end else begin
        state_d = state_q - 2'd1;
        pos_d   = pos_q - 32'd1;
      end
    end else if (running) begin
      cnt_d = cnt_q + PeriodOne;
    end else begin
      cnt_d = '0;
    end

    if (i_load && step_now) begin
      // Load coincides with a boundary: the step above used the old direction,
      // the new command governs the next interval directly.
      act_period_d = i_period;
      act_dir_d    = i_dir;
      pending_d    = 1'b0;
    end else if (i_load) begin
      pend_period_d = i_period;
      pend_dir_d    = i_dir;
      pending_d     = 1'b1;
    end else if (pending_q && (step_now || !running)) begin
      act_period_d = pend_period_q;
      act_dir_d    = pend_dir_q;
      pending_d    = 1'b0;
      cnt_d        = '0;
    end
  end

  // Channel levels of the next state, registered so outputs are glitch-free.
  always_comb begin
    cha_d = 1'b0;
    chb_d = 1'b0;
    unique case (state_d)
      S0: begin cha_d = 1'b0; chb_d = 1'b0; end
      S1: begin cha_d = 1'b1; chb_d = 1'b0; end
      S2: begin cha_d = 1'b1; chb_d = 1'b1; end
      S3: begin cha_d = 1'b0; chb_d = 1'b1; end
      default: begin cha_d = 1'b0; chb_d = 1'b0; end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q       <= S0;
      cha_q         <= 1'b0;
      chb_q         <= 1'b0;
      step_q        <= 1'b0;
      pos_q         <= '0;
      cnt_q         <= '0;
      act_period_q  <= '0;
      act_dir_q     <= 1'b1;
      pend_period_q <= '0;
      pend_dir_q    <= 1'b1;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cha_q         <= cha_d;
      chb_q         <= chb_d;
      step_q        <= step_now;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      act_period_q  <= act_period_d;
      act_dir_q     <= act_dir_d;
      pend_period_q <= pend_period_d;
      pend_dir_q    <= pend_dir_d;
      pending_q     <= pending_d;
    end
  end

`ifdef QENC_INDEX_EN
  localparam int unsigned IdxW = (EDGES_PER_REV > 1) ? $clog2(EDGES_PER_REV) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(EDGES_PER_REV - 1);

  logic [IdxW-1:0] idx_q, idx_d;
  logic            chz_q;

  // Edge index follows the same direction as the position, wrapping both ways.
  always_comb begin
    idx_d = idx_q;
    if (step_now) begin
      if (step_dir) begin
        idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
      end else begin
        idx_d = (idx_q == '0) ? IdxMax : idx_q - IdxW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      idx_q <= '0;
      chz_q <= 1'b1;
    end else begin
      idx_q <= idx_d;
      chz_q <= (idx_d == '0);
    end
  end

  assign o_chZ = chz_q;
`endif

  assign o_pending  = pending_q;
  assign o_chA      = cha_q;
  assign o_chB      = chb_q;
  assign o_step     = step_q;
  assign o_position = pos_q;

endmodule

// File: tb/tb_quad_encoder_emu.sv
// Directed bench for quad_encoder_emu. Inputs change and outputs are sampled on
// the falling clock edge; every expected value below is worked out by hand from
// the command/interval timing (load edge -> pending, apply edge -> counter 0,
// then a step on every P'-th rising edge).

module tb_quad_encoder_emu;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [31:0] period;
  logic        dir;
  logic        load;
  logic        pend;
  logic        cha;
  logic        chb;
  logic        step;
  logic [31:0] pos;
`ifdef QENC_INDEX_EN
  logic        chz;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  quad_encoder_emu #(
    .EDGES_PER_REV(8),
    .PERIOD_W     (32)
  ) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_en      (en),
    .i_period  (period),
    .i_dir     (dir),
    .i_load    (load),
    .o_pending (pend),
    .o_chA     (cha),
    .o_chB     (chb),
`ifdef QENC_INDEX_EN
    .o_chZ     (chz),
`endif
    .o_step    (step),
    .o_position(pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // p-1 quiet edges, then one step edge landing on the given A/B and position.
  task automatic interval(input int p, input logic [1:0] ab, input logic [31:0] exp_pos,
                          input string tag);
    for (int i = 0; i < p - 1; i++) begin
      tick();
      chk({tag, "_quiet"}, {31'd0, step}, 32'd0);
    end
    tick();
    chk({tag, "_step"}, {31'd0, step}, 32'd1);
    chk({tag, "_ab"}, {30'd0, cha, chb}, {30'd0, ab});
    chk({tag, "_pos"}, pos, exp_pos);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; load = 1'b0; period = 32'd0; dir = 1'b0;
    tick();
    tick();
    chk("rst_ab", {30'd0, cha, chb}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_pos", pos, 32'd0);
    chk("rst_pend", {31'd0, pend}, 32'd0);
`ifdef QENC_INDEX_EN
    chk("rst_chz", {31'd0, chz}, 32'd1);
`endif
    rstn = 1'b1;

    // Forward at period 4 from halt: load edge, apply edge, then steps.
    en = 1'b1; load = 1'b1; period = 32'd4; dir = 1'b1;
    tick();
    load = 1'b0;
    chk("fwd_pend_set", {31'd0, pend}, 32'd1);
    tick();
    chk("fwd_pend_clr", {31'd0, pend}, 32'd0);
    interval(4, 2'b10, 32'd1, "fwd1");
    interval(4, 2'b11, 32'd2, "fwd2");
    interval(4, 2'b01, 32'd3, "fwd3");
    interval(4, 2'b00, 32'd4, "fwd4");

    // Reversal from S2: the boundary step goes back to S1.
    interval(4, 2'b10, 32'd5, "fwd5");
    interval(4, 2'b11, 32'd6, "fwd6");
    load = 1'b1; period = 32'd4; dir = 1'b0;
    tick();
    load = 1'b0;
    chk("rev_pend_set", {31'd0, pend}, 32'd1);
    interval(3, 2'b10, 32'd5, "rev1");
    chk("rev_pend_clr", {31'd0, pend}, 32'd0);
    interval(4, 2'b00, 32'd4, "rev2");
    interval(4, 2'b01, 32'd3, "rev3");

    // Period 8 reverse, then a load landing exactly on a step (8 -> 3, fwd).
    load = 1'b1; period = 32'd8; dir = 1'b0;
    tick();
    load = 1'b0;
    interval(3, 2'b11, 32'd2, "p8_apply");
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("p8_quiet", {31'd0, step}, 32'd0);
    end
    load = 1'b1; period = 32'd3; dir = 1'b1;
    tick();
    load = 1'b0;
    chk("coinc_step", {31'd0, step}, 32'd1);
    chk("coinc_ab", {30'd0, cha, chb}, 32'b10);
    chk("coinc_pos", pos, 32'd1);
    chk("coinc_pend", {31'd0, pend}, 32'd0);
    interval(3, 2'b11, 32'd2, "p3");
    chk("p3_pend", {31'd0, pend}, 32'd0);

    // Period 1 behaves as 2, then period 0 halts after one pending cycle.
    load = 1'b1; period = 32'd1; dir = 1'b1;
    tick();
    load = 1'b0;
    chk("p1_pend", {31'd0, pend}, 32'd1);
    interval(2, 2'b01, 32'd3, "p1_apply");
    interval(2, 2'b00, 32'd4, "p1_a");
    interval(2, 2'b10, 32'd5, "p1_b");
    load = 1'b1; period = 32'd0; dir = 1'b1;
    tick();
    load = 1'b0;
    chk("p0_pend_set", {31'd0, pend}, 32'd1);
    chk("p0_nostep", {31'd0, step}, 32'd0);
    tick();
    chk("p0_last_step", {31'd0, step}, 32'd1);
    chk("p0_last_ab", {30'd0, cha, chb}, 32'b11);
    chk("p0_last_pos", pos, 32'd6);
    chk("p0_pend_clr", {31'd0, pend}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("halt_step", {31'd0, step}, 32'd0);
      chk("halt_ab", {30'd0, cha, chb}, 32'b11);
      chk("halt_pos", pos, 32'd6);
    end

    // Enable gating: command applies while disabled, first step P' after enable.
    en = 1'b0; load = 1'b1; period = 32'd4; dir = 1'b1;
    tick();
    load = 1'b0;
    chk("en_pend_set", {31'd0, pend}, 32'd1);
    tick();
    chk("en_pend_clr", {31'd0, pend}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis_step", {31'd0, step}, 32'd0);
    end
    en = 1'b1;
    interval(4, 2'b01, 32'd7, "en1");
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_step", {31'd0, step}, 32'd0);
      chk("frz_ab", {30'd0, cha, chb}, 32'b01);
      chk("frz_pos", pos, 32'd7);
    end
    en = 1'b1;
    interval(4, 2'b00, 32'd8, "en2");

    // Signed wrap of the position across 0x7FFFFFFF.
    force dut.pos_q = 32'h7FFF_FFFF;
    tick();
    chk("wrap_preload", pos, 32'h7FFF_FFFF);
    release dut.pos_q;
    interval(3, 2'b10, 32'h8000_0000, "wrap");

    // Reset mid-interval with a command pending.
    tick();
    load = 1'b1; period = 32'd5; dir = 1'b0;
    tick();
    load = 1'b0;
    chk("rst2_pend_pre", {31'd0, pend}, 32'd1);
    rstn = 1'b0;
    tick();
    chk("rst2_pend", {31'd0, pend}, 32'd0);
    chk("rst2_step", {31'd0, step}, 32'd0);
    chk("rst2_ab", {30'd0, cha, chb}, 32'd0);
    chk("rst2_pos", pos, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst2_idle_step", {31'd0, step}, 32'd0);
      chk("rst2_idle_pos", pos, 32'd0);
    end

`ifdef QENC_INDEX_EN
    // Index with EDGES_PER_REV = 8 at period 2: Z on every 8th step, wrap in reverse.
    chk("idx_rst_chz", {31'd0, chz}, 32'd1);
    load = 1'b1; period = 32'd2; dir = 1'b1;
    tick();
    load = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      logic [1:0] ab;
      case (k % 4)
        0:       ab = 2'b00;
        1:       ab = 2'b10;
        2:       ab = 2'b11;
        default: ab = 2'b01;
      endcase
      interval(2, ab, 32'(k), "idx_fwd");
      chk("idx_fwd_chz", {31'd0, chz}, (k % 8 == 0) ? 32'd1 : 32'd0);
    end
    load = 1'b1; period = 32'd2; dir = 1'b0;
    tick();
    load = 1'b0;
    interval(1, 2'b01, 32'd7, "idx_rev");
    chk("idx_rev_chz", {31'd0, chz}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_encoder_emu.md
QUAD_ENCODER_EMU -- requirements
Module: quad_encoder_emu

Interface
REQ-001 Parameter EDGES_PER_REV, default 48: quadrature state transitions per shaft revolution, legal range 4..65535.
REQ-002 Parameter PERIOD_W, default 32: width of the step-period input.
REQ-003 Port i_clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 Port i_rstn, input, 1: synchronous, active-low reset.
REQ-005 Port i_en, input, 1: step enable; low freezes the emulated shaft.
REQ-006 Port i_period, input, PERIOD_W: requested clocks between quadrature transitions; 0 means halt.
REQ-007 Port i_dir, input, 1: requested direction; 1 forward (A leads B), 0 reverse.
REQ-008 Port i_load, input, 1: single-cycle strobe capturing i_period and i_dir into the pending register.
REQ-009 Port o_pending, output, 1: a loaded command is not yet applied.
REQ-010 Port o_chA, output, 1: registered quadrature channel A.
REQ-011 Port o_chB, output, 1: registered quadrature channel B.
REQ-012 Port o_chZ, output, 1: registered index channel; exists only with QENC_INDEX_EN.
REQ-013 Port o_step, output, 1: one-cycle pulse in the cycle the A/B state changes.
REQ-014 Port o_position, output, 32: signed transition count, two's complement.

Function
REQ-015 Quadrature states SHALL be S0(A0,B0), S1(A1,B0), S2(A1,B1), S3(A0,B1); forward goes S0->S1->S2->S3->S0, reverse the opposite; exactly one channel changes per step.
REQ-016 The active period SHALL come from an internal register; an active period of 1 SHALL be treated as 2, and 0 SHALL produce no steps.
REQ-017 Interval counter: while i_en=1 and active period P>=2, count 0..P'-1, where P' is P after the REQ-016 clamp; at count P'-1 take a step and return to 0, so steps are exactly P' clocks apart.
REQ-018 A step SHALL update o_chA/o_chB, pulse o_step, and change o_position by +1 (forward) or -1 (reverse), wrapping modulo 2^32, all in the same cycle.
REQ-019 i_load=1: capture i_period/i_dir into pending and set o_pending the next cycle; a later load before application overwrites the pending value.
REQ-020 A pending command SHALL be applied when the next step occurs, or the next cycle if the active period is 0 or i_en=0; on application the counter clears and o_pending falls.
REQ-021 When a step and a load fall in the same cycle: the step uses the old direction, and the new command applies at that same boundary, so the next interval uses the new values.
REQ-022 A direction change SHALL never skip a quadrature state: the first step after a reversal returns to the previous state.
REQ-023 i_en=0: outputs hold, the counter holds at 0, o_step stays 0; after i_en rises, the first step occurs P' clocks later.
REQ-024 Outputs SHALL be glitch-free registers, with no combinational path from any input to o_chA, o_chB or o_chZ.

Reset
REQ-025 With i_rstn=0 at a clock edge: state S0, o_chA=0, o_chB=0, o_step=0, o_position=0, counter 0, active period 0 (halted), active dir 1, pending cleared, o_pending=0, edge index 0.
REQ-026 Reset mid-interval or with a command pending SHALL discard the command, and no step pulse is emitted in the reset cycle.

Configuration
REQ-027 Macro QENC_INDEX_EN defined: keep an edge index 0..EDGES_PER_REV-1, incremented on forward steps and decremented on reverse steps, wrapping both ways.
REQ-028 With QENC_INDEX_EN, o_chZ SHALL be 1 exactly while the edge index is 0, which gives o_chZ=1 out of reset.
REQ-029 Macro QENC_INDEX_EN undefined: no index counter and no o_chZ port; all other behaviour identical.

Verification
REQ-030 Reset, then load period 4, dir 1, en 1 -> sequence 00,10,11,01,00 (A,B) with steps 4 clocks apart; o_position goes 1,2,3,4.
REQ-031 Running forward at period 4, load dir 0 -> at the next boundary the state steps back (S2->S1), then o_position decrements once per step.
REQ-032 Load period 1 -> steps every 2 clocks; load period 0 -> no further o_step and outputs frozen; o_pending high for exactly one cycle.
REQ-033 Preload o_position at 0x7FFFFFFF (forced) and step forward -> 0x80000000, with no other side effects.
REQ-034 Load in the same cycle as a step (period 8->3) -> the step occurs, the next step follows 3 clocks later, and o_pending never asserts beyond that cycle.
REQ-035 With QENC_INDEX_EN and EDGES_PER_REV=8, period 2 forward -> o_chZ high for 2 clocks every 16 clocks; in reverse the index wraps from 0 to 7.
